// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the single-port dmem between the CPU load/store path and a DMA requester.
// Optional DMEM_ARB_LOCK_EN adds dma_lock, which lets the DMA owner ignore the hold limit.
module dmem_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_HOLD = 8
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          cpu_req,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    input  logic          cpu_we,
    input  logic [2:0]    cpu_op,
    output logic          cpu_gnt,
    output logic          cpu_stall,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,

    input  logic          dma_req,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    input  logic          dma_we,
    input  logic [2:0]    dma_op,
`ifdef DMEM_ARB_LOCK_EN
    input  logic          dma_lock,
`endif
    output logic          dma_gnt,
    output logic          dma_stall,
    output logic          dma_rvalid,
    output logic [DW-1:0] dma_rdata,

    output logic [AW-1:0] dmem_addr,
    output logic [DW-1:0] dmem_wdata,
    output logic [2:0]    dmem_op,
    output logic          dmem_we,
    input  logic [DW-1:0] dmem_rdata
);

    // state    | meaning
    // IDLE     | nobody owns dmem, no grants
    // OWN_CPU  | CPU owns dmem, cpu_gnt follows cpu_req
    // OWN_DMA  | DMA owns dmem, dma_gnt follows dma_req
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_OWN_CPU = 2'd1,
        ST_OWN_DMA = 2'd2
    } state_t;

    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

    state_t        state_q, state_d;
    logic          last_dma_q, last_dma_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic [1:0]    rd_pend_q, rd_pend_d;
    logic          lock_act;

`ifdef DMEM_ARB_LOCK_EN
    assign lock_act = dma_lock;
`else
    assign lock_act = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            last_dma_q <= 1'b1;
            hold_cnt_q <= '0;
            rd_pend_q  <= 2'b00;
        end else begin
            state_q    <= state_d;
            last_dma_q <= last_dma_d;
            hold_cnt_q <= hold_cnt_d;
            rd_pend_q  <= rd_pend_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        last_dma_d = last_dma_q;
        hold_cnt_d = hold_cnt_q;
        // A grant always implies a request, so gnt alone marks an accepted transaction.
        rd_pend_d  = {dma_gnt & ~dma_we, cpu_gnt & ~cpu_we};
        case (state_q)
            ST_IDLE: begin
                if (cpu_req && dma_req) state_d = last_dma_q ? ST_OWN_CPU : ST_OWN_DMA;
                else if (cpu_req)       state_d = ST_OWN_CPU;
                else if (dma_req)       state_d = ST_OWN_DMA;
            end
            ST_OWN_CPU: begin
                if (!cpu_req)                              state_d = dma_req ? ST_OWN_DMA : ST_IDLE;
                else if (hold_cnt_q == HOLD_LAST && dma_req) state_d = ST_OWN_DMA;
                else if (hold_cnt_q != HOLD_LAST)          hold_cnt_d = hold_cnt_q + 1'b1;
            end
            ST_OWN_DMA: begin
                if (!dma_req)                                           state_d = cpu_req ? ST_OWN_CPU : ST_IDLE;
                else if (hold_cnt_q == HOLD_LAST && cpu_req && !lock_act) state_d = ST_OWN_CPU;
                else if (hold_cnt_q != HOLD_LAST)                       hold_cnt_d = hold_cnt_q + 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
        if (state_d != state_q) hold_cnt_d = '0;
        if (state_d == ST_OWN_CPU && state_q != ST_OWN_CPU) last_dma_d = 1'b0;
        if (state_d == ST_OWN_DMA && state_q != ST_OWN_DMA) last_dma_d = 1'b1;
    end

    always_comb begin
        cpu_gnt    = 1'b0;
        dma_gnt    = 1'b0;
        dmem_addr  = '0;
        dmem_wdata = '0;
        dmem_op    = 3'b000;
        dmem_we    = 1'b0;
        case (state_q)
            ST_OWN_CPU: begin
                cpu_gnt    = cpu_req;
                dmem_addr  = cpu_addr;
                dmem_wdata = cpu_wdata;
                dmem_op    = cpu_op;
                dmem_we    = cpu_req & cpu_we;
            end
            ST_OWN_DMA: begin
                dma_gnt    = dma_req;
                dmem_addr  = dma_addr;
                dmem_wdata = dma_wdata;
                dmem_op    = dma_op;
                dmem_we    = dma_req & dma_we;
            end
            default: ;
        endcase
    end

    assign cpu_stall  = cpu_req & ~cpu_gnt;
    assign dma_stall  = dma_req & ~dma_gnt;
    assign cpu_rvalid = rd_pend_q[0];
    assign dma_rvalid = rd_pend_q[1];
    assign cpu_rdata  = rd_pend_q[0] ? dmem_rdata : '0;
    assign dma_rdata  = rd_pend_q[1] ? dmem_rdata : '0;

endmodule
